// File: rtl/uart_pkg.sv
// Shared register map, bit positions and TX FSM encoding for the UART register controller.
package uart_pkg;

    localparam int unsigned STAT_IDX = 0;
    localparam int unsigned CTRL_IDX = 1;
    localparam int unsigned TX_IDX   = 2;
    localparam int unsigned RX_IDX   = 3;

    localparam int unsigned CTRL_TX_EN    = 0;
    localparam int unsigned CTRL_RX_EN    = 1;
    localparam int unsigned CTRL_TX_START = 2;

    localparam int unsigned STAT_RX_VALID   = 0;
    localparam int unsigned STAT_TX_BUSY    = 1;
    localparam int unsigned STAT_TX_DONE    = 2;
    localparam int unsigned STAT_RX_OVERRUN = 16;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_LOAD = 3'd1,
        ST_SEND = 3'd2,
        ST_WAIT = 3'd3,
        ST_DONE = 3'd4
    } tx_state_e;

endpackage

// File: rtl/uart_rx_capture.sv
// Received-byte capture: builds the RX register word and the STAT bits to set,
// flagging overrun when a previous byte is still marked valid.
module uart_rx_capture
    import uart_pkg::*;
#(
    parameter int unsigned REG_WIDTH = 32
) (
    input  logic                 rx_en_i,
    input  logic                 rx_valid_i,
    input  logic [7:0]           rx_data_i,
    input  logic                 rx_pending_i,
    output logic                 rx_wr_o,
    output logic [REG_WIDTH-1:0] rx_word_o,
    output logic [REG_WIDTH-1:0] stat_set_o
);

    always_comb begin
        rx_wr_o    = 1'b0;
        rx_word_o  = '0;
        stat_set_o = '0;
        if (rx_en_i && rx_valid_i) begin
            rx_wr_o                     = 1'b1;
            rx_word_o[7:0]              = rx_data_i;
            stat_set_o[STAT_RX_VALID]   = 1'b1;
            stat_set_o[STAT_RX_OVERRUN] = rx_pending_i;
        end
    end

endmodule

// File: rtl/uart_reg_ctrl.sv
// UART register controller: TX FSM driving the transmitter, RX capture, and a
// merged read-modify-write of STAT that defers around CPU STAT reads.
module uart_reg_ctrl
    import uart_pkg::*;
#(
    parameter int unsigned REG_WIDTH = 32,
    parameter int unsigned REG_COUNT = 4
) (
    input  logic                           clk_i,
    input  logic                           rst_i,
    input  logic [REG_COUNT*REG_WIDTH-1:0] periph_data_i,
    input  logic                           cpu_stat_rd_i,
    output logic [REG_COUNT*REG_WIDTH-1:0] periph_data_o,
    output logic [REG_COUNT-1:0]           wr_en_periph_o,
    output logic [7:0]                     tx_data_o,
    output logic                           tx_valid_o,
    input  logic                           tx_ready_i,
    input  logic                           tx_done_i,
    input  logic [7:0]                     rx_data_i,
    input  logic                           rx_valid_i
);

    tx_state_e                      state_q, state_d;
    logic [7:0]                     tx_data_q, tx_data_d;
    logic [REG_COUNT-1:0]           wr_en_q, wr_en_d;
    logic [REG_COUNT*REG_WIDTH-1:0] periph_data_q, periph_data_d;
    logic                           pend_vld_q, pend_vld_d;
    logic [REG_WIDTH-1:0]           pend_set_q, pend_set_d;
    logic [REG_WIDTH-1:0]           pend_clr_q, pend_clr_d;

    logic [REG_WIDTH-1:0] stat_in, ctrl_in, tx_in, stat_base;
    logic [REG_WIDTH-1:0] tx_set, tx_clr, ctrl_word;
    logic                 tx_vld, ctrl_wr;
    logic                 rx_wr;
    logic [REG_WIDTH-1:0] rx_word, rx_set;
    logic [REG_WIDTH-1:0] acc_set, acc_clr;
    logic                 acc_vld;
    logic                 unused_in;

    assign stat_in   = periph_data_i[STAT_IDX*REG_WIDTH +: REG_WIDTH];
    assign ctrl_in   = periph_data_i[CTRL_IDX*REG_WIDTH +: REG_WIDTH];
    assign tx_in     = periph_data_i[TX_IDX*REG_WIDTH +: REG_WIDTH];
    assign unused_in = ^periph_data_i;

    // The bank lags our registered write by a cycle, so an in-flight STAT write is the true base.
    assign stat_base = wr_en_q[STAT_IDX] ? periph_data_q[STAT_IDX*REG_WIDTH +: REG_WIDTH]
                                         : stat_in;

    uart_rx_capture #(
        .REG_WIDTH (REG_WIDTH)
    ) u_rx_capture (
        .rx_en_i      (ctrl_in[CTRL_RX_EN]),
        .rx_valid_i   (rx_valid_i),
        .rx_data_i    (rx_data_i),
        .rx_pending_i (stat_base[STAT_RX_VALID] | pend_set_q[STAT_RX_VALID]),
        .rx_wr_o      (rx_wr),
        .rx_word_o    (rx_word),
        .stat_set_o   (rx_set)
    );

    always_comb begin
        state_d   = state_q;
        tx_data_d = tx_data_q;
        tx_set    = '0;
        tx_clr    = '0;
        tx_vld    = 1'b0;
        ctrl_wr   = 1'b0;
        ctrl_word = ctrl_in;
        unique case (state_q)
            ST_IDLE: begin
                if (ctrl_in[CTRL_TX_EN] && ctrl_in[CTRL_TX_START]) state_d = ST_LOAD;
            end
            ST_LOAD: begin
                tx_data_d                = tx_in[7:0];
                ctrl_wr                  = 1'b1;
                ctrl_word[CTRL_TX_START] = 1'b0;
                tx_vld                   = 1'b1;
                tx_set[STAT_TX_BUSY]     = 1'b1;
                tx_clr[STAT_TX_DONE]     = 1'b1;
                state_d                  = ST_SEND;
            end
            ST_SEND: begin
                if (tx_ready_i) begin
                    state_d = ST_WAIT;
                end else if (!ctrl_in[CTRL_TX_EN]) begin
                    tx_vld               = 1'b1;
                    tx_clr[STAT_TX_BUSY] = 1'b1;
                    tx_clr[STAT_TX_DONE] = 1'b1;
                    state_d              = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (tx_done_i) state_d = ST_DONE;
            end
            ST_DONE: begin
                tx_vld               = 1'b1;
                tx_clr[STAT_TX_BUSY] = 1'b1;
                tx_set[STAT_TX_DONE] = 1'b1;
                state_d              = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Newer updates override older pending ones bit by bit; a CPU STAT read parks the lot.
    assign acc_set = (pend_set_q & ~tx_clr) | tx_set | rx_set;
    assign acc_clr = (pend_clr_q & ~(tx_set | rx_set)) | tx_clr;
    assign acc_vld = pend_vld_q | tx_vld | rx_wr;

    always_comb begin
        wr_en_d       = '0;
        periph_data_d = '0;
        pend_vld_d    = 1'b0;
        pend_set_d    = '0;
        pend_clr_d    = '0;
        if (ctrl_wr) begin
            wr_en_d[CTRL_IDX]                                 = 1'b1;
            periph_data_d[CTRL_IDX*REG_WIDTH +: REG_WIDTH] = ctrl_word;
        end
        if (rx_wr) begin
            wr_en_d[RX_IDX]                                 = 1'b1;
            periph_data_d[RX_IDX*REG_WIDTH +: REG_WIDTH] = rx_word;
        end
        if (acc_vld) begin
            if (cpu_stat_rd_i) begin
                pend_vld_d = 1'b1;
                pend_set_d = acc_set;
                pend_clr_d = acc_clr;
            end else begin
                wr_en_d[STAT_IDX]                                 = 1'b1;
                periph_data_d[STAT_IDX*REG_WIDTH +: REG_WIDTH] = (stat_base & ~acc_clr) | acc_set;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q       <= ST_IDLE;
            tx_data_q     <= '0;
            wr_en_q       <= '0;
            periph_data_q <= '0;
            pend_vld_q    <= 1'b0;
            pend_set_q    <= '0;
            pend_clr_q    <= '0;
        end else begin
            state_q       <= state_d;
            tx_data_q     <= tx_data_d;
            wr_en_q       <= wr_en_d;
            periph_data_q <= periph_data_d;
            pend_vld_q    <= pend_vld_d;
            pend_set_q    <= pend_set_d;
            pend_clr_q    <= pend_clr_d;
        end
    end

    assign periph_data_o  = periph_data_q;
    assign wr_en_periph_o = wr_en_q;
    assign tx_data_o      = tx_data_q;
    assign tx_valid_o     = (state_q == ST_SEND);

endmodule

// File: doc/uart_reg_ctrl.md
UART_REG_CTRL -- requirements
Module: uart_reg_ctrl

Interface
REQ-001 SHALL have parameter REG_WIDTH, default 32: width of each UART register.
REQ-002 SHALL have parameter REG_COUNT, default 4: number of registers (STAT=0, CTRL=1, TX=2, RX=3).
REQ-003 SHALL have port clk_i  input  1  clock; one clock, all logic on its rising edge.
REQ-004 SHALL have port rst_i  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port periph_data_i  input  REG_COUNT*REG_WIDTH  current register contents (periph_data_o of the register bank).
REQ-006 SHALL have port cpu_stat_rd_i  input  1  CPU read strobe of STAT register this cycle.
REQ-007 SHALL have port periph_data_o  output  REG_COUNT*REG_WIDTH  write-back data to the register bank.
REQ-008 SHALL have port wr_en_periph_o  output  REG_COUNT  per-register write enables to the register bank.
REQ-009 SHALL have port tx_data_o  output  8  byte to transmitter core.
REQ-010 SHALL have port tx_valid_o  output  1  byte valid to transmitter.
REQ-011 SHALL have port tx_ready_i  input  1  transmitter accepts byte.
REQ-012 SHALL have port tx_done_i  input  1  one-cycle pulse, last stop bit sent.
REQ-013 SHALL have port rx_data_i  input  8  received byte.
REQ-014 SHALL have port rx_valid_i  input  1  one-cycle pulse, rx_data_i valid.

Function
REQ-015 Register bits SHALL be: CTRL[0] TX_EN, CTRL[1] RX_EN, CTRL[2] TX_START; STAT[0] RX_VALID, STAT[1] TX_BUSY, STAT[2] TX_DONE, STAT[16] RX_OVERRUN; TX[7:0] and RX[7:0] data.
REQ-016 TX FSM SHALL have states IDLE, LOAD, SEND, WAIT, DONE.
REQ-017 IDLE->LOAD when TX_EN=1 and TX_START=1; else stay.
REQ-018 LOAD (1 cycle): latch TX[7:0] into tx_data_o, write CTRL with TX_START=0 (other bits unchanged), write STAT with TX_BUSY=1, TX_DONE=0; -> SEND.
REQ-019 SEND: tx_valid_o=1, tx_data_o stable; on tx_valid_o&tx_ready_i -> WAIT; if TX_EN=0 -> IDLE with STAT TX_BUSY=0, TX_DONE=0.
REQ-020 WAIT: tx_valid_o=0; on tx_done_i -> DONE; TX_EN=0 does not abort.
REQ-021 DONE (1 cycle): write STAT TX_BUSY=0, TX_DONE=1; -> IDLE.
REQ-022 tx_valid_o SHALL be asserted only in SEND; minimum TX_START-to-tx_valid_o latency 2 cycles.
REQ-023 RX: on rx_valid_i with RX_EN=1, write RX[7:0]=rx_data_i (RX[31:8]=0) and set STAT RX_VALID=1; if RX_VALID already 1, also set RX_OVERRUN=1 and overwrite RX.
REQ-024 rx_valid_i with RX_EN=0 SHALL be ignored.
REQ-025 Every STAT write SHALL be read-modify-write of periph_data_i STAT with only the bits named changed; simultaneous TX and RX updates SHALL merge into one write.
REQ-026 If cpu_stat_rd_i=1 in a cycle with a pending STAT update, the STAT write SHALL be deferred one cycle and re-based on the post-clear value; pending updates SHALL accumulate, never drop.
REQ-027 A byte arriving during a deferred cycle SHALL still write RX immediately; only STAT is deferred.
REQ-028 wr_en_periph_o bits SHALL be single-cycle pulses, registered; unwritten slots of periph_data_o SHALL be 0.

Reset
REQ-029 On rst_i: FSM=IDLE, tx_valid_o=0, tx_data_o=0, wr_en_periph_o=0, periph_data_o=0, pending STAT update cleared.
REQ-030 Reset mid-transfer SHALL drop tx_valid_o next cycle without a STAT write.

Structure
REQ-031 Register indices, bit positions and FSM state encodings SHALL live in shared package uart_pkg.
REQ-032 RX capture/overrun logic SHALL be sub-module uart_rx_capture; TX FSM and STAT merge stay in the top module.

Verification
REQ-033 CTRL=0x5, TX=0xA5, tx_ready_i=1 -> tx_valid_o high cycle 2, tx_data_o=0xA5, CTRL write 0x1, STAT TX_BUSY=1; tx_done_i -> STAT TX_DONE=1, TX_BUSY=0.
REQ-034 CTRL=0x2, rx_valid_i with 0x3C twice, no read -> RX=0x3C, STAT=0x00010001.
REQ-035 rx_valid_i coincident with cpu_stat_rd_i -> RX written same cycle, RX_VALID set one cycle later, not lost.
REQ-036 TX in SEND, tx_ready_i=0, clear TX_EN -> IDLE, tx_valid_o=0, STAT TX_BUSY=0.
REQ-037 rx_valid_i in same cycle as DONE -> single STAT write with RX_VALID=1, TX_DONE=1, TX_BUSY=0.
REQ-038 rst_i asserted during WAIT -> all outputs 0 next cycle, FSM IDLE, no spurious wr_en_periph_o.
